mxn_set_packer: RTL

Streaming packer that accepts one WIDTH-bit operand set per cycle over a valid/ready handshake and assembles SETS of them into one SETS*WIDTH packed word for the mXn-bit gate array. Set i lands at bits [i*WIDTH +: WIDTH], the same packed layout the mXn gate wrappers consume. It is the sequential front end that lets a narrow producer feed the wide packed operand buses. `in_last` flushes a partial word early.

---
 rtl/mxn_set_packer.sv | 98 +++++++++
 1 files changed

// File: rtl/mxn_set_packer.sv
// Streaming packer: gathers SETS operand sets of WIDTH bits into one packed word
// (set i at bits [i*WIDTH +: WIDTH]); in_last flushes a partial word early.
module mxn_set_packer #(
    parameter int WIDTH = 4,
    parameter int SETS  = 2,
    localparam int CW   = $clog2(SETS + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      in_set,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [SETS*WIDTH-1:0] out_packed,
    output logic [CW-1:0]         out_count,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int IW = (SETS > 1) ? $clog2(SETS) : 1;

    if (WIDTH < 1) begin : g_bad_width
        $error("mxn_set_packer: WIDTH must be >= 1");
    end
    if (SETS < 1) begin : g_bad_sets
        $error("mxn_set_packer: SETS must be >= 1");
    end

    typedef enum logic {EMPTY, FILLING} fill_e;

    fill_e                 state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [SETS*WIDTH-1:0] acc_q, acc_d;
    logic [SETS*WIDTH-1:0] packed_q, packed_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  valid_q, valid_d;

    logic                  accept, emit, complete;
    logic [SETS*WIDTH-1:0] merged;

    // out_ready -> in_ready is combinational so a draining word frees the slot at once
    assign in_ready = rst_n && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign emit     = valid_q && out_ready;
    assign complete = accept && ((idx_q == IW'(SETS - 1)) || in_last);

    always_comb begin
        merged = (state_q == EMPTY) ? '0 : acc_q;
        merged[int'(idx_q)*WIDTH +: WIDTH] = in_set;
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        packed_d = packed_q;
        count_d  = count_q;
        valid_d  = valid_q;
        if (emit) begin
            valid_d = 1'b0;
        end
        if (complete) begin
            packed_d = merged;
            count_d  = CW'(int'(idx_q) + 1);
            valid_d  = 1'b1;
            acc_d    = '0;
            idx_d    = '0;
            state_d  = EMPTY;
        end else if (accept) begin
            acc_d   = merged;
            idx_d   = idx_q + IW'(1);
            state_d = FILLING;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            idx_q    <= '0;
            acc_q    <= '0;
            packed_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            packed_q <= packed_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    assign out_packed = packed_q;
    assign out_count  = count_q;
    assign out_valid  = valid_q;

endmodule
